hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Generates the stall and flush controls consumed by the IF/ID pipeline register (`enable`, `reset_hazard`), the PC write enable and the ID/EX bubble insert for the 5-stage pipeline.
- Detects load-use hazards and branch-operand hazards; branches are resolved in ID.
- Handles taken branches that resolve while instruction fetch is stalled by holding the target until fetch is ready.
- Keeps saturating stall and flush counters for performance checks.

Parameters:
N, 32, datapath/PC width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock, posedge
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction is branch/jump-register (needs operands in ID)
idex_mem_read  in  1  instruction in EX is a load
idex_reg_write  in  1  instruction in EX writes a register
idex_rd  in  5  destination register of EX instruction (post-mux)
exmem_mem_read  in  1  instruction in MEM is a load
exmem_rd  in  5  destination register of MEM instruction
branch_taken  in  1  ID-resolved taken branch/jump
branch_target  in  N  target address for branch_taken
imem_ready  in  1  instruction memory delivers valid fetch this cycle
pc_write  out  1  PC update enable
if_id_enable  out  1  to IF/ID enable
if_id_flush  out  1  to IF/ID reset_hazard (synchronous flush)
id_ex_flush  out  1  bubble insert into ID/EX
pc_redirect_sel  out  1  PC mux selects pc_redirect_target
pc_redirect_target  out  N  stored branch target
redirect_pending  out  1  high while in WAIT_FETCH
stall_cycles  out  CNT_W  cycles with pc_write=0
flush_count  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Registered state: FSM state, target register, counters.
  - All updated on posedge clk and cleared asynchronously by reset.
  - Control outputs are combinational from state and inputs.
  - Outputs are stable before the IF/ID negedge capture.
- Reset (reset=1): state=RUN; pc_redirect_target=0; counters=0. Forced outputs: pc_write=0, if_id_enable=0, if_id_flush=0, id_ex_flush=0, pc_redirect_sel=0, redirect_pending=0.
- Match rule: reg r matches when r!=0 and (r==id_rs or (id_uses_rt and r==id_rt)).
- Hazard terms:
  - H1 = idex_mem_read & match(idex_rd).
  - H2 = id_is_branch & idex_reg_write & !idex_mem_read & match(idex_rd).
  - H3 = id_is_branch & exmem_mem_read & match(exmem_rd).
  - data_stall = H1|H2|H3.
  - A branch dependent on a load therefore stalls 2 cycles: H1, then H3.
- State RUN, priority top-down:
  - data_stall: pc_write=0, if_id_enable=0, id_ex_flush=1. branch_taken is ignored.
  - branch_taken & imem_ready: pc_write=1, if_id_enable=1, if_id_flush=1 (kill wrong-path fetch). Stay in RUN.
  - branch_taken & !imem_ready: pc_write=0, if_id_flush=1. Latch branch_target, go to WAIT_FETCH.
  - !imem_ready: pc_write=0, if_id_flush=1 (bubble into ID).
  - Otherwise: pc_write=1, if_id_enable=1, flushes 0.
- State WAIT_FETCH:
  - redirect_pending=1, pc_redirect_sel=1, if_id_flush=1 every cycle.
  - branch_taken and data_stall are ignored, since ID holds a bubble.
  - imem_ready=0: pc_write=0, stay.
  - imem_ready=1: pc_write=1, go to RUN. Next cycle pc_redirect_sel=0.
- Counters: increment on posedge when the condition holds; saturate at all-ones (no wrap).
- Reset asserted mid-WAIT_FETCH: return to RUN immediately; the pending target is discarded.

Decomposition:
- Shared pipeline package: FSM state encoding (RUN=0, WAIT_FETCH=1) and REG_ZERO=5'd0 constant.
- One natural sub-module: sat_counter (parameter CNT_W, inc, clk, reset). Instantiate twice.

Test Plan:
1. Load-use: idex_mem_read=1, idex_rd=8, id_rs=8 -> pc_write=0, if_id_enable=0, id_ex_flush=1 for exactly 1 cycle; stall_cycles=1.
2. Branch on load: idex_mem_read=1, idex_rd=9, id_is_branch=1, id_rt=9, id_uses_rt=1; next cycle exmem_mem_read=1, exmem_rd=9 -> 2 consecutive stall cycles, then pc_write=1.
3. Register $0: idex_mem_read=1, idex_rd=0, id_rs=0 -> no stall; pc_write=1, if_id_enable=1.
4. Taken branch, fetch ready: branch_taken=1, imem_ready=1 -> if_id_flush=1 for one cycle, pc_write=1, flush_count=1.
5. Taken branch, fetch stalled: branch_taken=1, branch_target=0x0040_0100, imem_ready=0 for 3 cycles -> redirect_pending=1, if_id_flush=1, pc_write=0 for all 3. On imem_ready=1: pc_write=1, pc_redirect_sel=1, pc_redirect_target=0x0040_0100; RUN next cycle.
6. Async reset during WAIT_FETCH: reset=1 mid-clock -> all outputs and counters 0 immediately; after release, state RUN, pc_write=1 with imem_ready=1.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: FSM encoding,
// the hard-wired zero register and the register-dependency match helper.
package hazard_control_unit_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    WAIT_FETCH = 1'b1
  } hcu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer register r feeds the ID instruction when it is not $0 and
  // equals rs, or equals rt while the instruction actually reads rt.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: counts cycles where inc is high, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up on inc, holding once every bit is set so the value never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for the 5-stage pipeline. Detects load-use and
// branch-operand hazards and holds a taken-branch target while fetch stalls.
//
// Handshake: imem_ready is a per-cycle valid from instruction memory; the PC
// only advances (pc_write=1) in a cycle where imem_ready is high, and a
// redirect held in WAIT_FETCH is consumed in exactly that cycle.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic             branch_taken,
  input  logic [N-1:0]     branch_target,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_redirect_sel,
  output logic [N-1:0]     pc_redirect_target,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hcu_state_t state, state_next;
  logic       target_load;
  logic       h1, h2, h3, data_stall;

  assign h1 = idex_mem_read && reg_match(idex_rd, id_rs, id_rt, id_uses_rt);
  assign h2 = id_is_branch && idex_reg_write && !idex_mem_read &&
              reg_match(idex_rd, id_rs, id_rt, id_uses_rt);
  assign h3 = id_is_branch && exmem_mem_read &&
              reg_match(exmem_rd, id_rs, id_rt, id_uses_rt);
  assign data_stall = h1 || h2 || h3;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Branch target held for the redirect once fetch becomes ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            pc_redirect_target <= '0;
    else if (target_load) pc_redirect_target <= branch_target;
  end

  // Next state and control outputs; everything is forced low during reset.
  always_comb begin
    state_next       = state;
    target_load      = 1'b0;
    pc_write         = 1'b0;
    if_id_enable     = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    pc_redirect_sel  = 1'b0;
    redirect_pending = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (data_stall) begin
            id_ex_flush = 1'b1;
          end else if (branch_taken && imem_ready) begin
            pc_write     = 1'b1;
            if_id_enable = 1'b1;
            if_id_flush  = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            target_load = 1'b1;
            state_next  = WAIT_FETCH;
          end else if (!imem_ready) begin
            if_id_flush = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_enable = 1'b1;
          end
        end
        WAIT_FETCH: begin
          // ID holds a bubble here, so hazards and new branches are moot.
          redirect_pending = 1'b1;
          pc_redirect_sel  = 1'b1;
          if_id_flush      = 1'b1;
          if (imem_ready) begin
            pc_write   = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_control_unit;

  localparam int N     = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, idex_rd, exmem_rd;
  logic             id_uses_rt, id_is_branch, idex_mem_read, idex_reg_write;
  logic             exmem_mem_read, branch_taken, imem_ready;
  logic [N-1:0]     branch_target;
  logic             pc_write, if_id_enable, if_id_flush, id_ex_flush;
  logic             pc_redirect_sel, redirect_pending;
  logic [N-1:0]     pc_redirect_target;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;

  hazard_control_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_uses_rt         (id_uses_rt),
    .id_is_branch       (id_is_branch),
    .idex_mem_read      (idex_mem_read),
    .idex_reg_write     (idex_reg_write),
    .idex_rd            (idex_rd),
    .exmem_mem_read     (exmem_mem_read),
    .exmem_rd           (exmem_rd),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .imem_ready         (imem_ready),
    .pc_write           (pc_write),
    .if_id_enable       (if_id_enable),
    .if_id_flush        (if_id_flush),
    .id_ex_flush        (id_ex_flush),
    .pc_redirect_sel    (pc_redirect_sel),
    .pc_redirect_target (pc_redirect_target),
    .redirect_pending   (redirect_pending),
    .stall_cycles       (stall_cycles),
    .flush_count        (flush_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_rd = 5'd0;
    exmem_mem_read = 1'b0; exmem_rd = 5'd0;
    branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
  endtask

  task automatic drive_random();
    id_rs          = 5'($urandom_range(0, 3));
    id_rt          = 5'($urandom_range(0, 3));
    id_uses_rt     = 1'($urandom_range(0, 1));
    id_is_branch   = 1'($urandom_range(0, 1));
    idex_mem_read  = ($urandom_range(0, 3) == 0);
    idex_reg_write = 1'($urandom_range(0, 1));
    idex_rd        = 5'($urandom_range(0, 3));
    exmem_mem_read = ($urandom_range(0, 3) == 0);
    exmem_rd       = 5'($urandom_range(0, 3));
    branch_taken   = ($urandom_range(0, 3) == 0);
    branch_target  = $urandom;
    imem_ready     = ($urandom_range(0, 9) < 7);
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Model state: whether a redirect is outstanding, its target, and event
  // tallies. Counts saturate at 2^CNT_W-1.
  bit          m_pending;
  logic [N-1:0] m_target;
  longint      m_stalls, m_flushes;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  function automatic bit depends_on(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (r == id_rs) return 1'b1;
    return id_uses_rt && (r == id_rt);
  endfunction

  // Compare process: on each falling edge the outputs reflect the current
  // inputs and model state; then the model absorbs the coming rising edge.
  always @(negedge clk) begin
    bit e_pcw, e_en, e_iff, e_exf, e_sel, e_pend, stall;
    bit n_pending;
    logic [N-1:0] n_target;
    e_pcw = 0; e_en = 0; e_iff = 0; e_exf = 0; e_sel = 0; e_pend = 0;
    n_pending = m_pending;
    n_target  = m_target;
    if (!reset) begin
      check("model stall_cycles", stall_cycles, m_stalls);
      check("model flush_count", flush_count, m_flushes);
      check("model target", pc_redirect_target, m_target);
      stall = (idex_mem_read && depends_on(idex_rd)) ||
              (id_is_branch && idex_reg_write && !idex_mem_read && depends_on(idex_rd)) ||
              (id_is_branch && exmem_mem_read && depends_on(exmem_rd));
      if (m_pending) begin
        e_pend = 1; e_sel = 1; e_iff = 1; e_pcw = imem_ready;
        n_pending = !imem_ready;
      end else if (stall) begin
        e_exf = 1;
      end else if (branch_taken) begin
        e_iff = 1;
        if (imem_ready) begin
          e_pcw = 1; e_en = 1;
        end else begin
          n_pending = 1; n_target = branch_target;
        end
      end else if (!imem_ready) begin
        e_iff = 1;
      end else begin
        e_pcw = 1; e_en = 1;
      end
    end
    check("model pc_write", pc_write, e_pcw);
    check("model if_id_enable", if_id_enable, e_en);
    check("model if_id_flush", if_id_flush, e_iff);
    check("model id_ex_flush", id_ex_flush, e_exf);
    check("model pc_redirect_sel", pc_redirect_sel, e_sel);
    check("model redirect_pending", redirect_pending, e_pend);
    if (reset) begin
      m_pending = 0; m_target = '0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_pending = n_pending;
      m_target  = n_target;
      if (!e_pcw && m_stalls < CNT_MAX) m_stalls++;
      if (e_iff && m_flushes < CNT_MAX) m_flushes++;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    m_pending = 0; m_target = '0; m_stalls = 0; m_flushes = 0;
    repeat (3) next_cycle();

    // reset state, sampled while reset is held
    check("reset pc_write", pc_write, 0);
    check("reset if_id_enable", if_id_enable, 0);
    check("reset stall_cycles", stall_cycles, 0);

    // 1: load-use stalls one cycle
    reset = 1'b0;
    idex_mem_read = 1; idex_rd = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    check("t1 pc_write", pc_write, 0);
    check("t1 if_id_enable", if_id_enable, 0);
    check("t1 id_ex_flush", id_ex_flush, 1);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("t1 resume pc_write", pc_write, 1);
    check("t1 stall_cycles", stall_cycles, 1);

    // 2: branch on load stalls two cycles (EX then MEM)
    next_cycle();
    idex_mem_read = 1; idex_rd = 5'd9; id_is_branch = 1; id_rt = 5'd9; id_uses_rt = 1;
    @(negedge clk);
    check("t2 stall1 pc_write", pc_write, 0);
    next_cycle();
    idex_mem_read = 0; idex_reg_write = 0; idex_rd = 5'd3;
    exmem_mem_read = 1; exmem_rd = 5'd9;
    @(negedge clk);
    check("t2 stall2 pc_write", pc_write, 0);
    check("t2 stall2 id_ex_flush", id_ex_flush, 1);
    next_cycle();
    exmem_mem_read = 0;
    @(negedge clk);
    check("t2 resume pc_write", pc_write, 1);
    check("t2 stall_cycles", stall_cycles, 3);

    // 3: $0 never creates a dependency
    next_cycle();
    drive_idle();
    idex_mem_read = 1; idex_rd = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    check("t3 pc_write", pc_write, 1);
    check("t3 if_id_enable", if_id_enable, 1);

    // 4: taken branch with fetch ready kills one wrong-path fetch
    next_cycle();
    drive_idle();
    branch_taken = 1;
    @(negedge clk);
    check("t4 if_id_flush", if_id_flush, 1);
    check("t4 pc_write", pc_write, 1);
    next_cycle();
    branch_taken = 0;
    @(negedge clk);
    check("t4 flush_count", flush_count, 1);
    check("t4 flush cleared", if_id_flush, 0);

    // 5: taken branch while fetch stalled holds the target
    next_cycle();
    branch_taken = 1; branch_target = 32'h0040_0100; imem_ready = 0;
    @(negedge clk);
    check("t5 enter pc_write", pc_write, 0);
    check("t5 enter if_id_flush", if_id_flush, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      branch_taken = 0; branch_target = 32'h1234_5678;
      @(negedge clk);
      check("t5 wait redirect_pending", redirect_pending, 1);
      check("t5 wait if_id_flush", if_id_flush, 1);
      check("t5 wait pc_write", pc_write, 0);
    end
    next_cycle();
    imem_ready = 1;
    @(negedge clk);
    check("t5 go pc_write", pc_write, 1);
    check("t5 go pc_redirect_sel", pc_redirect_sel, 1);
    check("t5 go target", pc_redirect_target, 32'h0040_0100);
    next_cycle();
    @(negedge clk);
    check("t5 run pc_redirect_sel", pc_redirect_sel, 0);
    check("t5 run redirect_pending", redirect_pending, 0);

    // 6: async reset in WAIT_FETCH discards the redirect immediately
    next_cycle();
    branch_taken = 1; branch_target = 32'h0000_beef; imem_ready = 0;
    next_cycle();
    branch_taken = 0;
    #1 reset = 1'b1;
    #1;
    check("t6 reset redirect_pending", redirect_pending, 0);
    check("t6 reset if_id_flush", if_id_flush, 0);
    check("t6 reset stall_cycles", stall_cycles, 0);
    check("t6 reset flush_count", flush_count, 0);
    check("t6 reset target", pc_redirect_target, 0);
    next_cycle();
    reset = 1'b0; imem_ready = 1;
    @(negedge clk);
    check("t6 after pc_write", pc_write, 1);
    check("t6 after redirect_pending", redirect_pending, 0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      drive_random();
      reset = ($urandom_range(0, 199) == 0);
    end
    next_cycle();
    reset = 1'b0;
    drive_idle();
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
